hazard_sb: RTL and testbench

Scoreboarded hazard unit for the rv32 5-stage pipeline (F/D/E/M/W). It resolves forwarding selects for the D and E stages and generates stall/flush. It tracks in-flight writes from a variable-latency long unit (mul/div) in a per-register busy scoreboard. It also holds a branch/jump redirect that arrives during a memory stall and applies it when the stall releases.

---
 rtl/hazard_pkg.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 69 ++++++
 rtl/hazard_sb.sv | 144 ++++++++++++++
 tb/tb_hazard_sb.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared hazard-unit types: forwarding selects, stage control bits, redirect FSM states.
package hazard_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    RAW = 2'd0,
    ALU = 2'd1,
    MEM = 2'd2,
    WB  = 2'd3
  } register_data_sel;

  typedef struct packed {
    logic w;      // writes a register
    logic l;      // load
    logic w_mem;  // store
    logic j;      // jump
    logic b;      // conditional branch
    logic m;      // long-unit (mul/div) op
  } control_signals_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } redir_state_t;

  // Forwarding priority E > M > W; register 0 never matches.
  function automatic register_data_sel fwd_sel(
    input logic              e_en,
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_e,
    input logic              m_en,
    input logic [REG_AW-1:0] rd_m,
    input logic              w_en,
    input logic [REG_AW-1:0] rd_w
  );
    register_data_sel sel;
    sel = RAW;
    if (e_en && (rd_e != '0) && (rs == rd_e))      sel = ALU;
    else if (m_en && (rd_m != '0) && (rs == rd_m)) sel = MEM;
    else if (w_en && (rd_w != '0) && (rs == rd_w)) sel = WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register busy vector for long-unit writes, with a liveness watchdog that
// clears the vector and raises a sticky timeout if no completion arrives in time.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_N      = 32,
  parameter int unsigned LU_MAX_LAT = 34
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_rd_i,
  input  logic              clr_en_i,
  input  logic [REG_AW-1:0] clr_rd_i,
  input  logic [REG_AW-1:0] q0_i,
  input  logic [REG_AW-1:0] q1_i,
  input  logic [REG_AW-1:0] q2_i,
  output logic              busy0_o,
  output logic              busy1_o,
  output logic              busy2_o,
  output logic              lu_timeout_o
);

  localparam int unsigned WDW = $clog2(LU_MAX_LAT + 1);

  logic [REG_N-1:0] busy_q, busy_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             timeout_q, timeout_d;
  logic             wd_run, wd_expire;

  assign wd_run    = (|busy_q) && !clr_en_i;
  assign wd_expire = wd_run && (wd_q == WDW'(LU_MAX_LAT - 1));

  // Clear first so a same-edge new issue to the same register wins.
  always_comb begin
    busy_d    = busy_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (wd_expire) begin
      busy_d    = '0;
      wd_d      = '0;
      timeout_d = 1'b1;
    end else if (wd_run) begin
      wd_d = wd_q + WDW'(1);
    end else begin
      wd_d = '0;
    end
    if (clr_en_i) busy_d[clr_rd_i] = 1'b0;
    if (set_en_i) busy_d[set_rd_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy0_o      = busy_q[q0_i];
  assign busy1_o      = busy_q[q1_i];
  assign busy2_o      = busy_q[q2_i];
  assign lu_timeout_o = timeout_q;

endmodule

// File: rtl/hazard_sb.sv
// Hazard unit: forwarding selects, stall/flush generation, long-unit scoreboard and
// deferred redirect. Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int unsigned REG_N      = 32,
  parameter int unsigned LU_MAX_LAT = 34
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  control_signals_t  cs_e,
  input  control_signals_t  cs_m,
  input  control_signals_t  cs_w,
  input  logic              branch_hit,
  input  logic              lu_busy,
  input  logic              lu_done,
  input  logic [REG_AW-1:0] lu_done_rd,
  input  logic              dmem_ready,
  output register_data_sel  r1_sel,
  output register_data_sel  r2_sel,
  output register_data_sel  r1_e_sel,
  output register_data_sel  r2_e_sel,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              lu_timeout,
  output logic [31:0]       perf_lu_stall,
  output logic [31:0]       perf_mem_stall,
  output logic [31:0]       perf_ldu_stall,
  output logic [31:0]       perf_redirect
);

  redir_state_t state_q, state_d;
  logic busy_rs1_e, busy_rs2_e, busy_rd_e;
  logic mem_stall, lu_stall, ldu_stall, redir, lu_issue;
  logic unused_cs;

  assign unused_cs = ^{cs_e, cs_m, cs_w};

  assign r1_sel   = fwd_sel(cs_e.w, rs1,   rd_e, cs_m.w, rd_m, cs_w.w, rd_w);
  assign r2_sel   = fwd_sel(cs_e.w, rs2,   rd_e, cs_m.w, rd_m, cs_w.w, rd_w);
  assign r1_e_sel = fwd_sel(1'b0,   rs1_e, rd_e, cs_m.w, rd_m, cs_w.w, rd_w);
  assign r2_e_sel = fwd_sel(1'b0,   rs2_e, rd_e, cs_m.w, rd_m, cs_w.w, rd_w);

  assign mem_stall = !dmem_ready && (cs_m.l || cs_m.w_mem);
  assign lu_stall  = busy_rs1_e || busy_rs2_e || (cs_e.m && (busy_rd_e || lu_busy));
  assign ldu_stall = cs_e.l && (rd_e != '0) && ((rd_e == rs1) || (rd_e == rs2));
  assign redir     = cs_e.j || (cs_e.b && branch_hit);
  assign lu_issue  = cs_e.m && !stall_e && (rd_e != '0);

  hazard_scoreboard #(
    .REG_N      (REG_N),
    .LU_MAX_LAT (LU_MAX_LAT)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_en_i     (lu_issue),
    .set_rd_i     (rd_e),
    .clr_en_i     (lu_done),
    .clr_rd_i     (lu_done_rd),
    .q0_i         (rs1_e),
    .q1_i         (rs2_e),
    .q2_i         (rd_e),
    .busy0_o      (busy_rs1_e),
    .busy1_o      (busy_rs2_e),
    .busy2_o      (busy_rd_e),
    .lu_timeout_o (lu_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Priority: memory stall > redirect > long-unit stall > load-use.
  always_comb begin
    state_d = state_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      if (state_q == IDLE && redir) state_d = PEND;
    end else if (state_q == PEND || redir) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      state_d = IDLE;
    end else if (lu_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
    end else if (ldu_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_q, perf_mem_q, perf_ldu_q, perf_redir_q;

  // Each cycle credits only the cause that won the priority above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_q    <= '0;
      perf_mem_q   <= '0;
      perf_ldu_q   <= '0;
      perf_redir_q <= '0;
    end else begin
      if (stall_m)             perf_mem_q   <= perf_mem_q + 32'd1;
      if (stall_e && !stall_m) perf_lu_q    <= perf_lu_q + 32'd1;
      if (stall_d && !stall_e) perf_ldu_q   <= perf_ldu_q + 32'd1;
      if (flush_d)             perf_redir_q <= perf_redir_q + 32'd1;
    end
  end

  assign perf_lu_stall  = perf_lu_q;
  assign perf_mem_stall = perf_mem_q;
  assign perf_ldu_stall = perf_ldu_q;
  assign perf_redirect  = perf_redir_q;
`else
  assign perf_lu_stall  = '0;
  assign perf_mem_stall = '0;
  assign perf_ldu_stall = '0;
  assign perf_redirect  = '0;
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb: forwarding, load-use, scoreboard, redirect and watchdog.
module tb_hazard_sb;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1, rs2, rs1_e, rs2_e, rd_e, rd_m, rd_w, lu_done_rd;
  control_signals_t cs_e, cs_m, cs_w;
  logic branch_hit, lu_busy, lu_done, dmem_ready;
  register_data_sel r1_sel, r2_sel, r1_e_sel, r2_e_sel;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, lu_timeout;
  logic [31:0] perf_lu_stall, perf_mem_stall, perf_ldu_stall, perf_redirect;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_sb #(.REG_N(32), .LU_MAX_LAT(34)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1(rs1), .rs2(rs2), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .cs_e(cs_e), .cs_m(cs_m), .cs_w(cs_w),
    .branch_hit(branch_hit), .lu_busy(lu_busy), .lu_done(lu_done),
    .lu_done_rd(lu_done_rd), .dmem_ready(dmem_ready),
    .r1_sel(r1_sel), .r2_sel(r2_sel), .r1_e_sel(r1_e_sel), .r2_e_sel(r2_e_sel),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .lu_timeout(lu_timeout),
    .perf_lu_stall(perf_lu_stall), .perf_mem_stall(perf_mem_stall),
    .perf_ldu_stall(perf_ldu_stall), .perf_redirect(perf_redirect)
  );

  task automatic clr_inputs();
    rs1 = '0; rs2 = '0; rs1_e = '0; rs2_e = '0;
    rd_e = '0; rd_m = '0; rd_w = '0; lu_done_rd = '0;
    cs_e = '0; cs_m = '0; cs_w = '0;
    branch_hit = 1'b0; lu_busy = 1'b0; lu_done = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_inputs();
    dmem_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    total++;
    if ({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, lu_timeout} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, lu_timeout});
    end
    total++;
    if ({r1_sel, r2_sel, r1_e_sel, r2_e_sel} !== 8'h00) begin
      bad++;
      $display("FAIL reset_sel got=%h exp=00", {r1_sel, r2_sel, r1_e_sel, r2_e_sel});
    end
    total++;
    if ((perf_lu_stall | perf_mem_stall | perf_ldu_stall | perf_redirect) !== 32'd0) begin
      bad++;
      $display("FAIL reset_perf got=%h exp=0",
               perf_lu_stall | perf_mem_stall | perf_ldu_stall | perf_redirect);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_forwarding();
    clr_inputs();
    cs_e.w = 1'b1; rd_e = 5'd5; rs1 = 5'd5;
    #2;
    total++;
    if (r1_sel !== ALU) begin bad++; $display("FAIL fwd_alu got=%0d exp=%0d", r1_sel, ALU); end
    rd_e = 5'd0; rs1 = 5'd0;
    #1;
    total++;
    if (r1_sel !== RAW) begin bad++; $display("FAIL fwd_x0 got=%0d exp=%0d", r1_sel, RAW); end
    rd_e = 5'd5; rs1 = 5'd5; cs_m.w = 1'b1; rd_m = 5'd5;
    cs_w.w = 1'b1; rd_w = 5'd6; rs2 = 5'd6;
    #1;
    total++;
    if (r1_sel !== ALU) begin bad++; $display("FAIL fwd_e_over_m got=%0d exp=%0d", r1_sel, ALU); end
    total++;
    if (r2_sel !== WB) begin bad++; $display("FAIL fwd_wb got=%0d exp=%0d", r2_sel, WB); end
    cs_e.w = 1'b0;
    #1;
    total++;
    if (r1_sel !== MEM) begin bad++; $display("FAIL fwd_mem got=%0d exp=%0d", r1_sel, MEM); end
    rs1_e = 5'd5; rs2_e = 5'd6; cs_e.w = 1'b1;
    #1;
    total++;
    if (r1_e_sel !== MEM) begin bad++; $display("FAIL fwd_e_mem got=%0d exp=%0d", r1_e_sel, MEM); end
    total++;
    if (r2_e_sel !== WB) begin bad++; $display("FAIL fwd_e_wb got=%0d exp=%0d", r2_e_sel, WB); end
    rd_w = 5'd5;
    #1;
    total++;
    if (r1_e_sel !== MEM) begin bad++; $display("FAIL fwd_e_m_over_w got=%0d exp=%0d", r1_e_sel, MEM); end
    step();
  endtask

  task automatic test_load_use();
    clr_inputs();
    cs_e.l = 1'b1; cs_e.w = 1'b1; rd_e = 5'd7; rs2 = 5'd7; rs1 = 5'd3;
    #2;
    total++;
    if ({stall_f, stall_d, stall_e, flush_d, flush_e} !== 5'b11001) begin
      bad++;
      $display("FAIL ldu_stall got=%b exp=11001", {stall_f, stall_d, stall_e, flush_d, flush_e});
    end
    step();
    cs_e = '0; rd_e = '0; cs_m.l = 1'b1; cs_m.w = 1'b1; rd_m = 5'd7;
    #2;
    total++;
    if ({stall_f, stall_d, flush_e} !== 3'b000) begin
      bad++;
      $display("FAIL ldu_release got=%b exp=000", {stall_f, stall_d, flush_e});
    end
    total++;
    if (r2_sel !== MEM) begin bad++; $display("FAIL ldu_fwd got=%0d exp=%0d", r2_sel, MEM); end
    step();
    clr_inputs();
    cs_e.l = 1'b1; cs_e.w = 1'b1; cs_e.j = 1'b1; rd_e = 5'd7; rs1 = 5'd7;
    #2;
    total++;
    if ({stall_f, stall_d, flush_d, flush_e} !== 4'b0011) begin
      bad++;
      $display("FAIL redir_over_ldu got=%b exp=0011", {stall_f, stall_d, flush_d, flush_e});
    end
    step();
  endtask

  task automatic test_long_unit();
    clr_inputs();
    cs_e.m = 1'b1; cs_e.w = 1'b1; rd_e = 5'd10; lu_busy = 1'b1;
    #2;
    total++;
    if (stall_e !== 1'b1) begin bad++; $display("FAIL lu_struct got=%b exp=1", stall_e); end
    lu_busy = 1'b0; rd_e = 5'd9;
    #1;
    total++;
    if (stall_e !== 1'b0) begin bad++; $display("FAIL lu_issue got=%b exp=0", stall_e); end
    step();
    cs_e = '0; rd_e = '0; rs1_e = 5'd9;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        lu_done = 1'b1; lu_done_rd = 5'd9; cs_m.l = 1'b1; dmem_ready = 1'b0;
      end
      #2;
      total++;
      if ({stall_f, stall_e, flush_e} !== 3'b110) begin
        bad++;
        $display("FAIL lu_raw_stall cyc=%0d got=%b exp=110", i, {stall_f, stall_e, flush_e});
      end
      if (i == 1) begin
        rs1_e = 5'd0; cs_e.m = 1'b1; cs_e.w = 1'b1; rd_e = 5'd9;
        #1;
        total++;
        if (stall_e !== 1'b1) begin bad++; $display("FAIL lu_waw got=%b exp=1", stall_e); end
        rd_e = 5'd11;
        #1;
        total++;
        if (stall_e !== 1'b0) begin bad++; $display("FAIL lu_no_waw got=%b exp=0", stall_e); end
        rs1_e = 5'd9; cs_e = '0; rd_e = '0;
      end
      if (i == 2) begin
        cs_e.j = 1'b1;
        #1;
        total++;
        if ({stall_e, flush_d, flush_e} !== 3'b011) begin
          bad++;
          $display("FAIL lu_redir got=%b exp=011", {stall_e, flush_d, flush_e});
        end
        cs_e.j = 1'b0;
      end
      if (i == 4) begin
        total++;
        if (stall_m !== 1'b1) begin bad++; $display("FAIL lu_mem_prio got=%b exp=1", stall_m); end
      end
      step();
    end
    lu_done = 1'b0; cs_m = '0; dmem_ready = 1'b1;
    #2;
    total++;
    if (stall_e !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", stall_e); end
    total++;
    if (r1_e_sel !== RAW) begin bad++; $display("FAIL lu_release_sel got=%0d exp=%0d", r1_e_sel, RAW); end
    step();
  endtask

  task automatic test_redirect_pend();
    clr_inputs();
    cs_m.l = 1'b1; cs_m.w = 1'b1; dmem_ready = 1'b0; cs_e.j = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      total++;
      if ({stall_m, flush_d, flush_e} !== 3'b100) begin
        bad++;
        $display("FAIL pend_hold cyc=%0d got=%b exp=100", i, {stall_m, flush_d, flush_e});
      end
      step();
    end
    dmem_ready = 1'b1;
    #2;
    total++;
    if ({stall_f, flush_d, flush_e} !== 3'b011) begin
      bad++;
      $display("FAIL pend_apply got=%b exp=011", {stall_f, flush_d, flush_e});
    end
    step();
    cs_e = '0; cs_m = '0;
    #2;
    total++;
    if ({flush_d, flush_e} !== 2'b00) begin
      bad++;
      $display("FAIL pend_idle got=%b exp=00", {flush_d, flush_e});
    end
    step();
    cs_e.b = 1'b1; branch_hit = 1'b1;
    #2;
    total++;
    if ({flush_d, flush_e} !== 2'b11) begin
      bad++;
      $display("FAIL branch_taken got=%b exp=11", {flush_d, flush_e});
    end
    branch_hit = 1'b0;
    #1;
    total++;
    if ({flush_d, flush_e} !== 2'b00) begin
      bad++;
      $display("FAIL branch_not_taken got=%b exp=00", {flush_d, flush_e});
    end
    step();
    cs_e.j = 1'b1; cs_m.l = 1'b1; dmem_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cs_e = '0; cs_m = '0; dmem_ready = 1'b1;
    #2;
    total++;
    if ({flush_d, flush_e} !== 2'b00) begin
      bad++;
      $display("FAIL reset_drops_pend got=%b exp=00", {flush_d, flush_e});
    end
    step();
  endtask

  task automatic test_same_edge();
    clr_inputs();
    lu_done = 1'b1; lu_done_rd = 5'd4; cs_e.m = 1'b1; cs_e.w = 1'b1; rd_e = 5'd4;
    #2;
    total++;
    if (stall_e !== 1'b0) begin bad++; $display("FAIL same_edge_issue got=%b exp=0", stall_e); end
    step();
    lu_done = 1'b0; cs_e = '0; rd_e = '0; rs1_e = 5'd4;
    #2;
    total++;
    if (stall_e !== 1'b1) begin bad++; $display("FAIL same_edge_set_wins got=%b exp=1", stall_e); end
    lu_done = 1'b1;
    step();
    lu_done = 1'b0;
    #2;
    total++;
    if (stall_e !== 1'b0) begin bad++; $display("FAIL same_edge_cleanup got=%b exp=0", stall_e); end
    step();
  endtask

  task automatic test_watchdog();
    clr_inputs();
    cs_e.m = 1'b1; cs_e.w = 1'b1; rd_e = 5'd3;
    step();
    cs_e = '0; rd_e = '0; rs1_e = 5'd3;
    for (int i = 0; i < 33; i++) step();
    #2;
    total++;
    if ({lu_timeout, stall_e} !== 2'b01) begin
      bad++;
      $display("FAIL wd_before got=%b exp=01", {lu_timeout, stall_e});
    end
    step();
    #2;
    total++;
    if ({lu_timeout, stall_e} !== 2'b10) begin
      bad++;
      $display("FAIL wd_expire got=%b exp=10", {lu_timeout, stall_e});
    end
    step();
    #2;
    total++;
    if (lu_timeout !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%b exp=1", lu_timeout); end
    rst_n = 1'b0;
    #1;
    total++;
    if (lu_timeout !== 1'b0) begin bad++; $display("FAIL wd_reset got=%b exp=0", lu_timeout); end
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_long_unit();
    test_redirect_pend();
    test_same_edge();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
